// File: rtl/awg_cfg_ctrl_pkg.sv
// Shared constants for the AWG config path: frame header, register map,
// field widths and the receive FSM encoding.
package awg_cfg_ctrl_pkg;

  localparam int STATE_W = 5;
  localparam int FREQ_W  = 12;
  localparam int AMP_W   = 3;
  localparam int PHASE_W = 8;

  localparam logic [7:0] FRAME_HDR   = 8'hA5;
  localparam logic [7:0] ADDR_STATE  = 8'h01;
  localparam logic [7:0] ADDR_FREQ   = 8'h02;
  localparam logic [7:0] ADDR_AMP    = 8'h03;
  localparam logic [7:0] ADDR_PHASE  = 8'h04;
  localparam logic [7:0] ADDR_COMMIT = 8'h0F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_OK,
    ST_GOT_ADDR,
    ST_GOT_DHI,
    ST_GOT_DLO
  } rx_st_t;

  function automatic logic addr_legal(input logic [7:0] a);
    return (a == ADDR_STATE) || (a == ADDR_FREQ) || (a == ADDR_AMP) ||
           (a == ADDR_PHASE) || (a == ADDR_COMMIT);
  endfunction

endpackage

// File: rtl/awg_frame_rx.sv
// Frame receiver: tracks A5/ADDR/DHI/DLO/CSUM, verifies checksum and address,
// and aborts a frame whose inter-byte gap reaches TIMEOUT_CYC.
module awg_frame_rx
  import awg_cfg_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        wr_stb,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  rx_st_t        st;
  logic [CW-1:0] cnt;
  logic [7:0]    addr_q, dhi_q, dlo_q;
  logic          expire, csum_byte, good;

  // Strobes are decoded from the CSUM byte itself so the top can register
  // frame_ok, the shadow write and the commit on the same edge.
  assign expire    = (st != ST_IDLE) && (cnt == CW'(TIMEOUT_CYC));
  assign csum_byte = rx_valid && !expire && (st == ST_GOT_DLO);
  assign good      = (rx_data == (addr_q ^ dhi_q ^ dlo_q)) && addr_legal(addr_q);
  assign wr_stb    = csum_byte && good;
  assign frame_err = expire || (csum_byte && !good);
  assign wr_addr   = addr_q;
  assign wr_data   = {dhi_q, dlo_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= ST_IDLE;
      cnt    <= '0;
      addr_q <= '0;
      dhi_q  <= '0;
      dlo_q  <= '0;
    end else begin
      if (rx_valid || st == ST_IDLE) cnt <= '0;
      else                           cnt <= cnt + 1'b1;

      // On expiry the byte of that cycle is treated as if the FSM were idle.
      if (expire) begin
        st <= (rx_valid && rx_data == FRAME_HDR) ? ST_HDR_OK : ST_IDLE;
      end else if (rx_valid) begin
        case (st)
          ST_IDLE:     if (rx_data == FRAME_HDR) st <= ST_HDR_OK;
          ST_HDR_OK:   begin addr_q <= rx_data; st <= ST_GOT_ADDR; end
          ST_GOT_ADDR: begin dhi_q  <= rx_data; st <= ST_GOT_DHI;  end
          ST_GOT_DHI:  begin dlo_q  <= rx_data; st <= ST_GOT_DLO;  end
          default:     st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/awg_cfg_ctrl.sv
// Shadow/live register bank for sig_gen: framed writes land in shadows and a
// commit copies all four to the live outputs in a single clock.
module awg_cfg_ctrl
  import awg_cfg_ctrl_pkg::*;
#(
  parameter logic [4:0]  DEF_STATE   = 5'd4,
  parameter logic [11:0] DEF_FREQ    = 12'd1,
  parameter logic [2:0]  DEF_AMP     = 3'd7,
  parameter logic [7:0]  DEF_PHASE   = 8'd0,
  parameter int          TIMEOUT_CYC = 1_000_000,
  parameter int          AUTO_COMMIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [4:0]  state,
  output logic [11:0] state_freq,
  output logic [2:0]  state_amp,
  output logic [7:0]  state_phase,
  output logic        cfg_update,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  logic        wr_stb, rx_err, commit;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        unused_hi;

  logic [STATE_W-1:0] sh_state, nx_state;
  logic [FREQ_W-1:0]  sh_freq,  nx_freq;
  logic [AMP_W-1:0]   sh_amp,   nx_amp;
  logic [PHASE_W-1:0] sh_phase, nx_phase;

  awg_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .wr_stb    (wr_stb),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (rx_err)
  );

  // No field is wider than 12 bits, so the top nibble never matters.
  assign unused_hi = ^wr_data[15:12];

  always_comb begin
    nx_state = sh_state;
    nx_freq  = sh_freq;
    nx_amp   = sh_amp;
    nx_phase = sh_phase;
    if (wr_stb) begin
      case (wr_addr)
        ADDR_STATE: nx_state = wr_data[STATE_W-1:0];
        ADDR_FREQ:  nx_freq  = wr_data[FREQ_W-1:0];
        ADDR_AMP:   nx_amp   = wr_data[AMP_W-1:0];
        ADDR_PHASE: nx_phase = wr_data[PHASE_W-1:0];
        default:    ;
      endcase
    end
  end

  // Live regs load from the next-shadow values so an auto-commit carries the
  // word written by the same frame.
  assign commit = wr_stb && ((wr_addr == ADDR_COMMIT) || (AUTO_COMMIT != 0));

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_state    <= DEF_STATE;
      sh_freq     <= DEF_FREQ;
      sh_amp      <= DEF_AMP;
      sh_phase    <= DEF_PHASE;
      state       <= DEF_STATE;
      state_freq  <= DEF_FREQ;
      state_amp   <= DEF_AMP;
      state_phase <= DEF_PHASE;
      cfg_update  <= 1'b0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_cnt     <= 8'h00;
    end else begin
      sh_state   <= nx_state;
      sh_freq    <= nx_freq;
      sh_amp     <= nx_amp;
      sh_phase   <= nx_phase;
      cfg_update <= commit;
      frame_ok   <= wr_stb;
      frame_err  <= rx_err;
      if (commit) begin
        state       <= nx_state;
        state_freq  <= nx_freq;
        state_amp   <= nx_amp;
        state_phase <= nx_phase;
      end
      if (rx_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_awg_cfg_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed frame outcomes, a monitor
// pops them whenever either DUT pulses frame_ok/frame_err/cfg_update.
module tb_awg_cfg_ctrl;

  localparam int TO = 16;

  typedef struct packed {
    logic        ok;
    logic        upd;
    logic [4:0]  st;
    logic [11:0] fq;
    logic [2:0]  am;
    logic [7:0]  ph;
    logic [7:0]  ec;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, rxv0, rst1, rxv1;
  logic [7:0]  rxd0, rxd1;
  logic [4:0]  st0, st1;
  logic [11:0] fq0, fq1;
  logic [2:0]  am0, am1;
  logic [7:0]  ph0, ph1, ec0, ec1;
  logic        upd0, upd1, fok0, fok1, fer0, fer1;

  awg_cfg_ctrl #(.TIMEOUT_CYC(TO), .AUTO_COMMIT(0)) dut (
    .clk(clk), .rst(rst0), .rx_valid(rxv0), .rx_data(rxd0),
    .state(st0), .state_freq(fq0), .state_amp(am0), .state_phase(ph0),
    .cfg_update(upd0), .frame_ok(fok0), .frame_err(fer0), .err_cnt(ec0)
  );

  awg_cfg_ctrl #(.TIMEOUT_CYC(TO), .AUTO_COMMIT(1)) dut_ac (
    .clk(clk), .rst(rst1), .rx_valid(rxv1), .rx_data(rxd1),
    .state(st1), .state_freq(fq1), .state_amp(am1), .state_phase(ph1),
    .cfg_update(upd1), .frame_ok(fok1), .frame_err(fer1), .err_cnt(ec1)
  );

  int  nvec = 0;
  int  nmis = 0;
  ev_t q0[$];
  ev_t q1[$];

  function automatic ev_t ev(input logic ok, input logic upd, input logic [4:0] s,
                             input logic [11:0] f, input logic [2:0] a,
                             input logic [7:0] p, input int ec);
    ev_t r;
    r.ok = ok; r.upd = upd; r.st = s; r.fq = f; r.am = a; r.ph = p; r.ec = 8'(ec);
    return r;
  endfunction

  task automatic cmp_ev(input string nm, input ev_t e, input ev_t a, input logic ferr);
    nvec++;
    if (a !== e || ferr !== !e.ok) begin
      nmis++;
      $display("FAIL %s: got ok=%0b err=%0b upd=%0b st=%h fq=%h am=%h ph=%h ec=%0d, expected ok=%0b err=%0b upd=%0b st=%h fq=%h am=%h ph=%h ec=%0d",
               nm, a.ok, ferr, a.upd, a.st, a.fq, a.am, a.ph, a.ec,
               e.ok, !e.ok, e.upd, e.st, e.fq, e.am, e.ph, e.ec);
    end
  endtask

  task automatic unexpected(input string nm);
    nvec++;
    nmis++;
    $display("FAIL %s: output pulse with no expected event queued", nm);
  endtask

  // Monitor
  always @(negedge clk) begin
    ev_t a;
    if (!rst0 && (fok0 || fer0 || upd0)) begin
      a = ev(fok0, upd0, st0, fq0, am0, ph0, int'(ec0));
      if (q0.size() == 0) unexpected("dut0_event");
      else cmp_ev("dut0_event", q0.pop_front(), a, fer0);
    end
    if (!rst1 && (fok1 || fer1 || upd1)) begin
      a = ev(fok1, upd1, st1, fq1, am1, ph1, int'(ec1));
      if (q1.size() == 0) unexpected("dut_ac_event");
      else cmp_ev("dut_ac_event", q1.pop_front(), a, fer1);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    if (d == 0) begin rxv0 = 1'b1; rxd0 = b; end
    else        begin rxv1 = 1'b1; rxd1 = b; end
    @(posedge clk); #1;
    rxv0 = 1'b0;
    rxv1 = 1'b0;
  endtask

  task automatic frame(input int d, input logic [7:0] a, input logic [7:0] hi,
                       input logic [7:0] lo, input logic [7:0] cs, input ev_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    send_byte(d, 8'hA5);
    send_byte(d, a);
    send_byte(d, hi);
    send_byte(d, lo);
    send_byte(d, cs);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    rxv0 = 1'b0; rxv1 = 1'b0; rxd0 = 8'h00; rxd1 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0;

    chk("rst_state", int'(st0), 4);
    chk("rst_freq",  int'(fq0), 1);
    chk("rst_amp",   int'(am0), 7);
    chk("rst_phase", int'(ph0), 0);
    chk("rst_errcnt", int'(ec0), 0);
    chk("rst_pulses", int'({upd0, fok0, fer0}), 0);

    // T1: freq write then commit
    frame(0, 8'h02, 8'h01, 8'h23, 8'h20, ev(1, 0, 4, 12'h001, 7, 0, 0));
    frame(0, 8'h0F, 8'h00, 8'h00, 8'h0F, ev(1, 1, 4, 12'h123, 7, 0, 0));
    chk("t1_freq_live", int'(fq0), 'h123);

    // T2: amp write stays in shadow until commit
    frame(0, 8'h03, 8'h00, 8'h05, 8'h06, ev(1, 0, 4, 12'h123, 7, 0, 0));
    chk("t2_amp_held", int'(am0), 7);
    frame(0, 8'h0F, 8'h00, 8'h00, 8'h0F, ev(1, 1, 4, 12'h123, 5, 0, 0));

    // T3: bad checksum
    frame(0, 8'h04, 8'h00, 8'h10, 8'h15, ev(0, 0, 4, 12'h123, 5, 0, 1));
    frame(0, 8'h0F, 8'h00, 8'h00, 8'h0F, ev(1, 1, 4, 12'h123, 5, 0, 1));

    // T4: inter-byte timeout, then a full frame is accepted
    q0.push_back(ev(0, 0, 4, 12'h123, 5, 0, 2));
    send_byte(0, 8'hA5);
    send_byte(0, 8'h01);
    repeat (TO + 4) @(posedge clk);
    #1;
    frame(0, 8'h01, 8'h00, 8'h02, 8'h03, ev(1, 0, 4, 12'h123, 5, 0, 2));
    frame(0, 8'h0F, 8'h00, 8'h00, 8'h0F, ev(1, 1, 2, 12'h123, 5, 0, 2));

    // Header lands exactly in the expiry cycle: error, then a new frame starts
    q0.push_back(ev(0, 0, 2, 12'h123, 5, 0, 3));
    send_byte(0, 8'hA5);
    send_byte(0, 8'h01);
    repeat (TO) @(posedge clk);
    #1;
    frame(0, 8'h02, 8'hFF, 8'hFF, 8'h02, ev(1, 0, 2, 12'h123, 5, 0, 3));

    // 0xA5 as in-frame data, then commit: freq upper bits dropped
    frame(0, 8'h04, 8'h00, 8'hA5, 8'hA1, ev(1, 0, 2, 12'h123, 5, 0, 3));
    frame(0, 8'h0F, 8'h00, 8'h00, 8'h0F, ev(1, 1, 2, 12'hFFF, 5, 8'hA5, 3));

    // Illegal address
    frame(0, 8'h05, 8'h00, 8'h00, 8'h05, ev(0, 0, 2, 12'hFFF, 5, 8'hA5, 4));

    // Junk in IDLE is silently dropped
    send_byte(0, 8'h00);
    send_byte(0, 8'hFF);
    send_byte(0, 8'h5A);
    repeat (3) @(posedge clk);
    #1;
    chk("junk_errcnt", int'(ec0), 4);

    // T5: saturate err_cnt
    for (int k = 1; k <= 300; k++)
      frame(0, 8'h04, 8'h00, 8'h10, 8'h15,
            ev(0, 0, 2, 12'hFFF, 5, 8'hA5, (4 + k > 255) ? 255 : 4 + k));
    repeat (2) @(posedge clk);
    #1;
    chk("t5_errcnt_sat", int'(ec0), 'hFF);

    // T6: auto-commit instance
    frame(1, 8'h01, 8'h00, 8'h03, 8'h02, ev(1, 1, 3, 12'h001, 7, 0, 0));
    chk("t6_state_auto", int'(st1), 3);
    send_byte(1, 8'hA5);
    send_byte(1, 8'h01);
    send_byte(1, 8'h00);
    rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    chk("t6_rst_state", int'(st1), 4);
    frame(1, 8'h03, 8'h00, 8'h02, 8'h01, ev(1, 1, 4, 12'h001, 2, 0, 0));

    repeat (5) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
